hazard_controller: RTL

Pipeline sequencing controller for the five-stage LEGv8 CPU. It sits beside the IF/ID/EX/MEM/WB pipe registers and produces every write-enable, bubble, flush and freeze signal they need. It detects load-use hazards using an internal shadow of the ID/EX destination, flushes the three younger stages on a taken branch resolved in MEM, and freezes the pipeline while a multi-cycle data-memory access is outstanding. It also keeps saturating performance counters and a sticky memory-timeout flag.

---
 rtl/hazard_pkg.sv | 10 +
 rtl/hazard_controller_if.sv | 43 ++++
 rtl/hazard_controller_sat_counter.sv | 28 ++
 rtl/hazard_controller.sv | 127 ++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the LEGv8 pipeline hazard controller.
package hazard_pkg;
    localparam logic [4:0] XZR           = 5'd31;
    localparam int         DEFAULT_CNT_W = 32;

    typedef enum logic {
        RUN,
        WAIT
    } hz_state_t;
endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline-side signal bundle of the hazard controller: ID/MEM status in, pipe-register controls out.
interface hazard_controller_if
    import hazard_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
);
    logic             id_valid;
    logic [4:0]       id_rn;
    logic [4:0]       id_rm;
    logic             id_uses_rn;
    logic             id_uses_rm;
    logic [4:0]       id_rd;
    logic             id_regwrite;
    logic             id_memread;
    logic             mem_br_taken;
    logic             mem_access;
    logic             dmem_ready;

    logic             pc_write;
    logic             ifid_write;
    logic             idex_bubble;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             pipe_freeze;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;
    logic             mem_timeout;

    modport master (
        output id_valid, id_rn, id_rm, id_uses_rn, id_uses_rm, id_rd,
               id_regwrite, id_memread, mem_br_taken, mem_access, dmem_ready,
        input  pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush,
               exmem_flush, pipe_freeze, stall_count, flush_count, mem_timeout
    );

    modport slave (
        input  id_valid, id_rn, id_rm, id_uses_rn, id_uses_rm, id_rd,
               id_regwrite, id_memread, mem_br_taken, mem_access, dmem_ready,
        output pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush,
               exmem_flush, pipe_freeze, stall_count, flush_count, mem_timeout
    );
endinterface

// File: rtl/hazard_controller_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/hazard_controller.sv
// Hazard/sequencing control for the five-stage LEGv8 pipe: load-use bubbles,
// taken-branch flushes, data-memory freeze, event counters and a sticky memory timeout.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int CNT_W    = DEFAULT_CNT_W,
    parameter int MAX_WAIT = 16
) (
    input  logic               clk,
    input  logic               reset,
    hazard_controller_if.slave hz
);
    localparam int              WC_W      = $clog2(MAX_WAIT + 1);
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MAX_WAIT - 1);

    hz_state_t        state_q, state_d;
    logic [4:0]       ex_rd_q, ex_rd_d;
    logic             ex_load_q, ex_load_d;
    logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic             mem_timeout_q, mem_timeout_d;
    logic             freeze, flush, load_use, stall;
    logic [CNT_W-1:0] stall_count, flush_count;

    always_comb begin
        freeze   = hz.mem_access & ~hz.dmem_ready;
        flush    = hz.mem_br_taken & ~freeze;
        load_use = hz.id_valid & ex_load_q & (ex_rd_q != XZR) &
                   ((hz.id_uses_rn & (hz.id_rn == ex_rd_q)) |
                    (hz.id_uses_rm & (hz.id_rm == ex_rd_q)));
        stall    = load_use & ~freeze & ~flush;
    end

    // Reset drives the flush-everything pattern combinationally so the pipe regs clear too.
    always_comb begin
        hz.pc_write    = 1'b0;
        hz.ifid_write  = 1'b0;
        hz.idex_bubble = 1'b0;
        hz.ifid_flush  = 1'b0;
        hz.idex_flush  = 1'b0;
        hz.exmem_flush = 1'b0;
        hz.pipe_freeze = 1'b0;
        if (!reset) begin
            hz.ifid_flush  = 1'b1;
            hz.idex_flush  = 1'b1;
            hz.exmem_flush = 1'b1;
        end else if (freeze) begin
            hz.pipe_freeze = 1'b1;
        end else if (flush) begin
            hz.pc_write    = 1'b1;
            hz.ifid_write  = 1'b1;
            hz.ifid_flush  = 1'b1;
            hz.idex_flush  = 1'b1;
            hz.exmem_flush = 1'b1;
        end else if (stall) begin
            hz.idex_bubble = 1'b1;
        end else begin
            hz.pc_write    = 1'b1;
            hz.ifid_write  = 1'b1;
        end
    end

    // Shadow of the EX-stage destination; a bubble or flush leaves a NOP behind.
    always_comb begin
        ex_rd_d   = ex_rd_q;
        ex_load_d = ex_load_q;
        if (!freeze) begin
            if (flush || stall) begin
                ex_load_d = 1'b0;
            end else begin
                ex_rd_d   = hz.id_rd;
                ex_load_d = hz.id_valid & hz.id_memread & hz.id_regwrite;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (freeze) state_d = WAIT;
            WAIT:    if (!freeze) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // wait_cnt counts consecutive frozen cycles, including the one that enters WAIT.
    always_comb begin
        wait_cnt_d    = '0;
        mem_timeout_d = mem_timeout_q | (freeze & (wait_cnt_q == WAIT_LAST));
        if (state_d == WAIT) begin
            wait_cnt_d = (wait_cnt_q == WAIT_LAST) ? wait_cnt_q : wait_cnt_q + WC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= RUN;
            ex_rd_q       <= XZR;
            ex_load_q     <= 1'b0;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ex_rd_q       <= ex_rd_d;
            ex_load_q     <= ex_load_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall | freeze),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush),
        .count (flush_count)
    );

    assign hz.stall_count = stall_count;
    assign hz.flush_count = flush_count;
    assign hz.mem_timeout = mem_timeout_q;
endmodule
